fsm_seq_monitor: RTL and testbench

Passive checker on the output side of the five-state sequencer: samples the sequencer's encoded outputs (Out1/Out2 code, odd/even) and its control inputs every cycle, decodes the code to a state index, predicts the next legal state, and flags any illegal code or illegal transition. It sits beside the sequencer in the system testbench and in silicon debug builds, and reports lock status, per-event pulses and a saturating error count.

---
 rtl/fsm_seq_pkg.sv | 36 +++
 rtl/fsm_code_decoder.sv | 35 +++
 rtl/fsm_seq_monitor.sv | 148 ++++++++++++++
 tb/tb_fsm_seq_monitor.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/fsm_seq_pkg.sv
// Shared definitions for the five-state sequencer monitor: output code map,
// decoded index type and the monitor's tracking states.
package fsm_seq_pkg;

  localparam int NUM_STATES = 5;
  localparam int CODE_W     = 6;

  typedef logic [2:0] idx_t;

  localparam idx_t IDX_FIRST   = 3'd0;
  localparam idx_t IDX_THIRD   = 3'd2;
  localparam idx_t IDX_FIFTH   = 3'd4;
  localparam idx_t IDX_ILLEGAL = 3'd7;

  // {out1,out2} as driven by the sequencer in each of its five states
  localparam logic [CODE_W-1:0] CODE_FIRST  = 6'b011_010;
  localparam logic [CODE_W-1:0] CODE_SECOND = 6'b101_100;
  localparam logic [CODE_W-1:0] CODE_THIRD  = 6'b010_111;
  localparam logic [CODE_W-1:0] CODE_FOURTH = 6'b110_011;
  localparam logic [CODE_W-1:0] CODE_FIFTH  = 6'b101_010;

  // Packed so a generate loop can slice entry gi with [gi*CODE_W +: CODE_W]
  localparam logic [NUM_STATES*CODE_W-1:0] CODE_TABLE =
    {CODE_FIFTH, CODE_FOURTH, CODE_THIRD, CODE_SECOND, CODE_FIRST};

  typedef enum logic {
    MON_SEARCH = 1'b0,
    MON_TRACK  = 1'b1
  } mon_state_t;

  // The sequencer drives even = idx[0] and odd = ~idx[0] in every legal state
  function automatic logic flags_consistent(input idx_t i, input logic even, input logic odd);
    return (even == i[0]) && (odd == ~i[0]);
  endfunction

endpackage

// File: rtl/fsm_code_decoder.sv
// Combinational decode of the sequencer's {out1,out2} code to a state index;
// unknown codes map to IDX_ILLEGAL with legal deasserted.
module fsm_code_decoder
  import fsm_seq_pkg::*;
(
  input  logic [2:0] out1,
  input  logic [2:0] out2,
  output idx_t       idx,
  output logic       legal
);

  logic [CODE_W-1:0]     code;
  logic [NUM_STATES-1:0] hit;

  assign code = {out1, out2};

  generate
    for (genvar gi = 0; gi < NUM_STATES; gi++) begin : g_hit
      assign hit[gi] = (code == CODE_TABLE[gi*CODE_W +: CODE_W]);
    end
  endgenerate

  // Codes are distinct, so at most one hit bit is ever set
  always_comb begin
    idx = IDX_ILLEGAL;
    for (int i = 0; i < NUM_STATES; i++) begin
      if (hit[i]) begin
        idx = idx_t'(i);
      end
    end
  end

  assign legal = |hit;

endmodule

// File: rtl/fsm_seq_monitor.sv
// Passive checker for the five-state sequencer: locks onto its output code,
// predicts each next state and flags illegal codes/transitions.
// Optional odd/even flag checking: define FSM_SEQ_MONITOR_PARITY_EN.
module fsm_seq_monitor
  import fsm_seq_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       out1,
  input  logic [2:0]       out2,
  input  logic             even,
  input  logic             odd,
  input  logic             pause,
  input  logic             restart,
  input  logic             goto_third,
  output logic [2:0]       idx,
  output logic             locked,
  output logic             mismatch,
  output logic             par_err,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] loop_count
);

  mon_state_t       state_reg;
  idx_t             exp_reg;
  idx_t             idx_reg;
  logic             locked_reg;
  logic             mismatch_reg;
  logic [CNT_W-1:0] err_count_reg;
  logic [CNT_W-1:0] loop_count_reg;

  idx_t             cur_idx;
  logic             cur_legal;
  idx_t             exp_next;
  logic             mismatch_now;
  logic             par_now;
  logic             loop_now;
  logic [1:0]       err_inc;
  logic [CNT_W:0]   err_sum;
  logic [CNT_W-1:0] err_count_next;
  logic [CNT_W-1:0] loop_count_next;

  fsm_code_decoder u_dec (
    .out1  (out1),
    .out2  (out2),
    .idx   (cur_idx),
    .legal (cur_legal)
  );

  // Sequencer transition rule; only consulted for legal indices
  function automatic idx_t next_idx(input idx_t cur, input logic rs, input logic ps, input logic gt);
    idx_t n;
    n = cur;
    if (cur == IDX_FIRST) begin
      n = (rs | ps) ? IDX_FIRST : idx_t'(1);
    end else if (cur == IDX_FIFTH) begin
      n = rs ? IDX_FIRST : (gt ? IDX_THIRD : IDX_FIFTH);
    end else if (rs) begin
      n = IDX_FIRST;
    end else if (!ps) begin
      n = cur + idx_t'(1);
    end
    return n;
  endfunction

  assign exp_next     = next_idx(cur_idx, restart, pause, goto_third);
  assign mismatch_now = (state_reg == MON_TRACK) && (!cur_legal || (cur_idx != exp_reg));
  assign loop_now     = (state_reg == MON_TRACK) && !mismatch_now &&
                        (idx_reg == IDX_FIFTH) && (cur_idx == IDX_THIRD);

`ifdef FSM_SEQ_MONITOR_PARITY_EN
  logic par_err_reg;

  assign par_now = cur_legal && !flags_consistent(cur_idx, even, odd);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_err_reg <= 1'b0;
    end else begin
      par_err_reg <= par_now;
    end
  end

  assign par_err = par_err_reg;
`else
  logic unused_flags;

  assign unused_flags = even ^ odd;
  assign par_now      = 1'b0;
  assign par_err      = 1'b0;
`endif

  // A cycle carrying both a mismatch and a parity error counts twice
  assign err_inc = {1'b0, mismatch_now} + {1'b0, par_now};
  assign err_sum = {1'b0, err_count_reg} + (CNT_W+1)'(err_inc);

  always_comb begin
    err_count_next  = err_sum[CNT_W] ? '1 : err_sum[CNT_W-1:0];
    loop_count_next = loop_count_reg;
    if (loop_now && (loop_count_reg != '1)) begin
      loop_count_next = loop_count_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= MON_SEARCH;
      exp_reg        <= IDX_FIRST;
      idx_reg        <= IDX_ILLEGAL;
      locked_reg     <= 1'b0;
      mismatch_reg   <= 1'b0;
      err_count_reg  <= '0;
      loop_count_reg <= '0;
    end else begin
      idx_reg        <= cur_idx;
      mismatch_reg   <= mismatch_now;
      err_count_reg  <= err_count_next;
      loop_count_reg <= loop_count_next;
      case (state_reg)
        MON_SEARCH: begin
          if (cur_legal) begin
            exp_reg    <= exp_next;
            state_reg  <= MON_TRACK;
            locked_reg <= 1'b1;
          end
        end
        MON_TRACK: begin
          // The offending sample is discarded; re-lock waits for the next legal code
          if (mismatch_now) begin
            state_reg  <= MON_SEARCH;
            locked_reg <= 1'b0;
          end else begin
            exp_reg <= exp_next;
          end
        end
      endcase
    end
  end

  assign idx        = idx_reg;
  assign locked     = locked_reg;
  assign mismatch   = mismatch_reg;
  assign err_count  = err_count_reg;
  assign loop_count = loop_count_reg;

endmodule

// File: tb/tb_fsm_seq_monitor.sv
// Self-checking bench for fsm_seq_monitor: directed scenarios plus random
// sequencer traffic compared each cycle against a behavioural model.
module tb_fsm_seq_monitor;

  localparam int CNT_W = 8;
  localparam int SAT   = (1 << CNT_W) - 1;
`ifdef FSM_SEQ_MONITOR_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic [2:0]       out1, out2;
  logic             even, odd, pause, restart, goto_third;
  logic [2:0]       idx;
  logic             locked, mismatch, par_err;
  logic [CNT_W-1:0] err_count, loop_count;

  int n_cmp  = 0;
  int n_fail = 0;

  int code_tab [5] = '{'b011010, 'b101100, 'b010111, 'b110011, 'b101010};

  // model state
  bit m_locked;
  int m_exp, m_idx, m_err, m_loop;
  bit m_mm, m_pe;

  fsm_seq_monitor #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .out1       (out1),
    .out2       (out2),
    .even       (even),
    .odd        (odd),
    .pause      (pause),
    .restart    (restart),
    .goto_third (goto_third),
    .idx        (idx),
    .locked     (locked),
    .mismatch   (mismatch),
    .par_err    (par_err),
    .err_count  (err_count),
    .loop_count (loop_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic int dec(input int code);
    for (int i = 0; i < 5; i++) begin
      if (code_tab[i] == code) return i;
    end
    return 7;
  endfunction

  function automatic int next_rule(input int i, input bit p, input bit r, input bit g);
    if (r) return 0;
    if (i == 0) return p ? 0 : 1;
    if (i == 4) return g ? 2 : 4;
    return p ? i : i + 1;
  endfunction

  function automatic int sat_add(input int a, input int b);
    return (a + b > SAT) ? SAT : a + b;
  endfunction

  task automatic model_reset();
    m_locked = 0; m_exp = 0; m_idx = 7; m_err = 0; m_loop = 0; m_mm = 0; m_pe = 0;
  endtask

  task automatic model_step(input int code, input bit p, input bit r, input bit g, input bit ev, input bit od);
    int ci, nx;
    bit mm, pe, lp;
    ci = dec(code);
    nx = next_rule(ci, p, r, g);
    mm = m_locked && (ci == 7 || ci != m_exp);
    pe = PAR_EN && ci != 7 && ((ev != (ci % 2 == 1)) || (od != (ci % 2 == 0)));
    lp = m_locked && !mm && m_idx == 4 && ci == 2;
    m_err  = sat_add(m_err, int'(mm) + int'(pe));
    m_loop = sat_add(m_loop, int'(lp));
    if (!m_locked) begin
      if (ci != 7) begin
        m_locked = 1;
        m_exp    = nx;
      end
    end else if (mm) begin
      m_locked = 0;
    end else begin
      m_exp = nx;
    end
    m_idx = ci; m_mm = mm; m_pe = pe;
  endtask

  task automatic check_model();
    chk("idx",        32'(idx),        32'(m_idx));
    chk("locked",     32'(locked),     32'(m_locked));
    chk("mismatch",   32'(mismatch),   32'(m_mm));
    chk("par_err",    32'(par_err),    32'(m_pe));
    chk("err_count",  32'(err_count),  32'(m_err));
    chk("loop_count", 32'(loop_count), 32'(m_loop));
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_idx"},      32'(idx),        32'd7);
    chk({tag, "_locked"},   32'(locked),     32'd0);
    chk({tag, "_mismatch"}, 32'(mismatch),   32'd0);
    chk({tag, "_par_err"},  32'(par_err),    32'd0);
    chk({tag, "_err"},      32'(err_count),  32'd0);
    chk({tag, "_loop"},     32'(loop_count), 32'd0);
  endtask

  // One clock: drive after the falling edge, sample 1 time unit after the rising edge
  task automatic step_raw(input int code, input bit p, input bit r, input bit g, input bit ev, input bit od);
    int cv;
    cv = code;
    {out1, out2} = cv[5:0];
    pause = p; restart = r; goto_third = g; even = ev; odd = od;
    @(posedge clk);
    model_step(code, p, r, g, ev, od);
    #1;
    check_model();
    @(negedge clk);
  endtask

  task automatic step_ok(input int c, input bit p, input bit r, input bit g);
    step_raw(code_tab[c], p, r, g, (c % 2 == 1), (c % 2 == 0));
  endtask

  initial begin
    rst = 1'b1;
    out1 = 3'd0; out2 = 3'd0; even = 0; odd = 0; pause = 0; restart = 0; goto_third = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;

    // Clean walk through all five states
    for (int c = 0; c < 5; c++) step_ok(c, 0, 0, 0);
    chk("walk_err", 32'(err_count), 32'd0);
    chk("walk_locked", 32'(locked), 32'd1);

    // FIFTH -> THIRD loops until loop_count saturates
    step_ok(4, 0, 0, 1);
    for (int n = 0; n < 300; n++) begin
      step_ok(2, 0, 0, 0);
      step_ok(3, 0, 0, 0);
      step_ok(4, 0, 0, 1);
    end
    chk("loop_sat", 32'(loop_count), 32'(SAT));

    // Pause ignored by the sequencer: expected hold at 1, code advances to 2
    step_ok(2, 0, 1, 0);
    step_ok(0, 0, 0, 0);
    step_ok(1, 1, 0, 0);
    step_ok(2, 0, 0, 0);
    chk("pause_mm", 32'(mismatch), 32'd1);
    chk("pause_unlock", 32'(locked), 32'd0);
    step_ok(3, 0, 0, 0);
    chk("relock", 32'(locked), 32'd1);

    // Illegal code in TRACK, then more illegal codes in SEARCH
    step_raw('b111111, 0, 0, 0, 0, 0);
    chk("illegal_idx", 32'(idx), 32'd7);
    for (int n = 0; n < 3; n++) step_raw('b000000, 0, 0, 0, 1, 1);
    chk("search_err", 32'(err_count), 32'd2);

    // Code 1 with inverted flags
    step_ok(0, 0, 0, 0);
    step_raw(code_tab[1], 0, 0, 0, 1'b0, 1'b1);
    chk("par_pulse", 32'(par_err), 32'(PAR_EN));
    chk("par_locked", 32'(locked), 32'd1);

    // Random sequencer traffic, mostly following the predicted sequence
    for (int n = 0; n < 500; n++) begin
      int r, code, ci;
      bit p, rs, g, ev, od;
      r = int'($urandom_range(0, 99));
      if (m_locked && r < 80) code = code_tab[m_exp];
      else if (r < 92) code = code_tab[$urandom_range(0, 4)];
      else code = int'($urandom_range(0, 63));
      p  = ($urandom_range(0, 7) == 0);
      rs = ($urandom_range(0, 7) == 0);
      g  = ($urandom_range(0, 7) == 0);
      ci = dec(code);
      if (ci == 7 || $urandom_range(0, 9) == 0) begin
        ev = $urandom_range(0, 1) == 1;
        od = $urandom_range(0, 1) == 1;
      end else begin
        ev = (ci % 2 == 1);
        od = (ci % 2 == 0);
      end
      step_raw(code, p, rs, g, ev, od);
    end

    // Build err_count = 5 from a fresh reset, then reset asynchronously mid-TRACK
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    step_ok(0, 0, 0, 0);
    for (int n = 0; n < 5; n++) begin
      step_raw('b111111, 0, 0, 0, 0, 0);
      step_ok(0, 0, 0, 0);
    end
    chk("pre_rst_err", 32'(err_count), 32'd5);
    chk("pre_rst_locked", 32'(locked), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check_reset_vals("async_rst");
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    step_ok(1, 0, 0, 0);
    step_ok(2, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
